// File: rtl/test_key_pad_pkg.sv
// test_key_pad_pkg: keypad row drives, key codes, row index type and the (row, columns) -> key decoder
package test_key_pad_pkg;
  typedef logic [1:0] row_idx_t;
  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } key_t;
  localparam logic [3:0] ROW0_DRV = 4'b0111;
  localparam logic [3:0] ROW1_DRV = 4'b1011;
  localparam logic [3:0] ROW2_DRV = 4'b1101;
  localparam logic [3:0] ROW3_DRV = 4'b1110;
  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;
  // indexed by {row, column}
  localparam logic [3:0] KEY_MAP [16] = '{
    KEY_1, KEY_2, KEY_3, KEY_A,
    KEY_4, KEY_5, KEY_6, KEY_B,
    KEY_7, KEY_8, KEY_9, KEY_C,
    KEY_STAR, KEY_0, KEY_HASH, KEY_D
  };
  function automatic logic [3:0] rowDrive(input row_idx_t row);
    return ~(4'b1000 >> row);
  endfunction
  function automatic key_t decodeKey(input row_idx_t row, input logic [3:0] pat);
    logic [1:0] col;
    key_t k;
    col = pat == 4'b0111 ? 2'd0 : pat == 4'b1011 ? 2'd1 : pat == 4'b1101 ? 2'd2 : 2'd3;
    k.valid = pat == 4'b0111 || pat == 4'b1011 || pat == 4'b1101 || pat == 4'b1110;
    k.code = KEY_MAP[{row, col}];
    return k;
  endfunction
endpackage

// File: rtl/test_key_pad_decode.sv
// test_key_pad_decode: combinational row index + active-low columns -> {valid, code}
//   row      : currently driven row index
//   keyPadIn : column sense, bit3 = column 0
//   valid    : exactly one column low
//   code     : key code for that row/column
module test_key_pad_decode
  import test_key_pad_pkg::*;
(
  input  row_idx_t   row,
  input  logic [3:0] keyPadIn,
  output logic       valid,
  output logic [3:0] code
);
  key_t k;
  always_comb k = decodeKey(row, keyPadIn);
  assign valid = k.valid;
  assign code = k.code;
endmodule

// File: rtl/test_key_pad.sv
// test_key_pad: 4x4 keypad scanner with repeat suppression; optional debounce via KEYPAD_DEBOUNCE_EN
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   keyPadIn  : column sense, active-low, bit3 = column 0
//   keyPadOut : one-cold row drive, 4'b0111 = row 0
//   outLED    : last accepted key code
//   keyValid  : one-cycle pulse on each newly accepted press
module test_key_pad
  import test_key_pad_pkg::*;
#(
  parameter int SCAN_DIV = 1,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] keyPadIn,
  output logic [3:0] keyPadOut,
  output logic [3:0] outLED,
  output logic       keyValid
);
  row_idx_t rowIdx;
  logic [15:0] dwell;
  logic armed, frameHit, rawValid, hit, sampleEdge;
  logic [3:0] rawCode;
  assign sampleEdge = dwell == 16'(SCAN_DIV - 1);
  test_key_pad_decode decode (.row(rowIdx), .keyPadIn(keyPadIn), .valid(rawValid), .code(rawCode));
`ifdef KEYPAD_DEBOUNCE_EN
  // per-row run length of identical valid samples, saturating at DEBOUNCE_SCANS
  logic [3:0] lastCode [4];
  logic [7:0] runLen [4];
  logic [7:0] nextLen;
  always_comb begin
    nextLen = !rawValid ? 8'd0 :
              runLen[rowIdx] != 8'd0 && lastCode[rowIdx] == rawCode ?
              (runLen[rowIdx] == 8'(DEBOUNCE_SCANS) ? runLen[rowIdx] : runLen[rowIdx] + 8'd1) : 8'd1;
    hit = nextLen == 8'(DEBOUNCE_SCANS);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        runLen[i] <= '0;
        lastCode[i] <= '0;
      end
    end else if (sampleEdge) begin
      runLen[rowIdx] <= nextLen;
      lastCode[rowIdx] <= rawCode;
    end
  end
`else
  always_comb hit = rawValid;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rowIdx <= '0;
      keyPadOut <= ROW0_DRV;
      dwell <= '0;
      outLED <= KEY_0;
      keyValid <= 1'b0;
      armed <= 1'b1;
      frameHit <= 1'b0;
    end else begin
      keyValid <= 1'b0;
      if (sampleEdge) begin
        dwell <= '0;
        rowIdx <= rowIdx + 2'd1;
        keyPadOut <= rowDrive(rowIdx + 2'd1);
        if (hit && armed) begin
          outLED <= rawCode;
          keyValid <= 1'b1;
          armed <= 1'b0;
        end
        // a frame closes on row 3; rearm only if the whole frame saw no key
        if (rowIdx == 2'd3) begin
          frameHit <= 1'b0;
          if (!(frameHit || hit)) armed <= 1'b1;
        end else if (hit) frameHit <= 1'b1;
      end else dwell <= dwell + 16'd1;
    end
  end
endmodule

// File: tb/tb_test_key_pad.sv
// tb_test_key_pad: directed + random checks of test_key_pad against a frame-level keypad model
module tb_test_key_pad;
  logic clk = 0, rst_n = 0;
  logic [3:0] keyPadIn = 4'hF;
  logic [3:0] keyPadOut, outLED;
  logic keyValid;
  int tests = 0, fails = 0, pulses = 0;
  int mRow = 0, mLed = 0;
  bit mArmed = 1, mHit = 0, mValid = 0;
  int keyMap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  test_key_pad dut (.clk(clk), .rst_n(rst_n), .keyPadIn(keyPadIn),
                    .keyPadOut(keyPadOut), .outLED(outLED), .keyValid(keyValid));

  always #5 clk = ~clk;

  task automatic step(input logic [3:0] pat, input logic rstv);
    int lows, col;
    logic [3:0] expRow;
    @(negedge clk);
    keyPadIn = pat;
    rst_n = rstv;
    @(posedge clk);
    #1;
    if (!rstv) begin
      mRow = 0; mArmed = 1; mHit = 0; mLed = 0; mValid = 0;
    end else begin
      mValid = 0;
      lows = 0;
      col = 0;
      for (int b = 0; b < 4; b++) if (pat[3-b] === 1'b0) begin lows++; col = b; end
      if (lows == 1 && !$isunknown(pat)) begin
        if (mArmed) begin mLed = keyMap[mRow*4+col]; mValid = 1; mArmed = 0; end
        mHit = 1;
      end
      if (mRow == 3) begin
        if (!mHit) mArmed = 1;
        mHit = 0;
      end
      mRow = (mRow + 1) % 4;
    end
    expRow = 4'hF;
    expRow[3-mRow] = 1'b0;
    if (keyValid) pulses++;
    tests += 3;
    assert (keyPadOut === expRow) else begin fails++; $error("FAIL keyPadOut got %b want %b", keyPadOut, expRow); end
    assert (outLED === 4'(mLed)) else begin fails++; $error("FAIL outLED got %h want %h", outLED, 4'(mLed)); end
    assert (keyValid === mValid) else begin fails++; $error("FAIL keyValid got %b want %b", keyValid, mValid); end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'hF, 1'b1);
  endtask

  task automatic toRow(input int r);
    while (mRow != r) step(4'hF, 1'b1);
  endtask

  // key at (r,c) pulls column c low only while row r is driven
  task automatic holdKey(input int r, input int c, input int n);
    logic [3:0] p;
    for (int i = 0; i < n; i++) begin
      p = 4'hF;
      if (mRow == r) p[3-c] = 1'b0;
      step(p, 1'b1);
    end
  endtask

  initial begin
    logic [3:0] p;
    step(4'hF, 1'b0);
    step(4'hF, 1'b0);
    idle(5);
    toRow(0); step(4'b1011, 1'b1);
    step(4'hF, 1'b1);
    toRow(0); idle(4);
    step(4'b0111, 1'b1);
    idle(3); idle(4);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b0011, 1'b1);
    idle(4);
    toRow(3); step(4'b1011, 1'b1); idle(4);
    toRow(3); step(4'b0111, 1'b1); idle(4);
    toRow(2); step(4'b1110, 1'b1); idle(4);
    toRow(0); idle(4);
    pulses = 0;
    holdKey(1, 1, 20);
    tests++;
    assert (pulses === 1) else begin fails++; $error("FAIL holdPulses got %0d want 1", pulses); end
    idle(8);
    toRow(2); holdKey(2, 0, 1);
    step(4'b0111, 1'b0);
    tests++;
    assert (outLED === 4'h0 && keyPadOut === 4'b0111) else begin fails++; $error("FAIL midReset got %h/%b want 0/0111", outLED, keyPadOut); end
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(9))
        0, 1, 2, 3, 4: p = 4'hF;
        5, 6, 7: begin p = 4'hF; p[$urandom_range(3)] = 1'b0; end
        default: p = 4'($urandom);
      endcase
      step(p, ($urandom_range(49) != 0));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
